// File: rtl/vxm_pkg.sv
// rtl/vxm_pkg.sv - opcode type and default sizes for the vector execution pipe
package vxm_pkg;

    localparam int VXM_LANE_WIDTH = 16;
    localparam int VXM_NUM_TILES  = 20;
    localparam int VXM_CNT_WIDTH  = 32;

    typedef enum logic [2:0] {
        VXM_ADD = 3'd0,
        VXM_SUB = 3'd1,
        VXM_MUL = 3'd2,
        VXM_MAX = 3'd3,
        VXM_MIN = 3'd4,
        VXM_AND = 3'd5,
        VXM_OR  = 3'd6,
        VXM_XOR = 3'd7
    } vxm_op_t;

endpackage

// File: rtl/vxm_lane_alu.sv
// rtl/vxm_lane_alu.sv - combinational single-lane ALU, saturating when VXM_SATURATE_EN is defined
module vxm_lane_alu
    import vxm_pkg::*;
#(
    parameter int LANE_WIDTH = VXM_LANE_WIDTH
) (
    input  logic [LANE_WIDTH-1:0] a,
    input  logic [LANE_WIDTH-1:0] b,
    input  vxm_op_t               op,
    input  logic                  mask,
`ifdef VXM_SATURATE_EN
    output logic                  sat,
`endif
    output logic [LANE_WIDTH-1:0] result
);

    logic [LANE_WIDTH-1:0] add_lo;
    logic [LANE_WIDTH-1:0] sub_lo;
    logic [LANE_WIDTH-1:0] mul_lo;
    logic [LANE_WIDTH-1:0] alu;

    assign add_lo = a + b;
    assign sub_lo = a - b;

`ifdef VXM_SATURATE_EN
    logic [LANE_WIDTH-1:0] mul_hi;
    logic                  ovf;

    // Full-width product so the upper half can flag multiply overflow
    assign {mul_hi, mul_lo} = {{LANE_WIDTH{1'b0}}, a} * {{LANE_WIDTH{1'b0}}, b};
`else
    assign mul_lo = a * b;
`endif

    // Wrapping lane operation selected by opcode
    always_comb begin
        alu = a;
        case (op)
            VXM_ADD: alu = add_lo;
            VXM_SUB: alu = sub_lo;
            VXM_MUL: alu = mul_lo;
            VXM_MAX: alu = (a > b) ? a : b;
            VXM_MIN: alu = (a < b) ? a : b;
            VXM_AND: alu = a & b;
            VXM_OR:  alu = a | b;
            VXM_XOR: alu = a ^ b;
            default: alu = a;
        endcase
    end

`ifdef VXM_SATURATE_EN
    // Overflow detection, clamping and mask pass-through; masked lanes never report saturation
    always_comb begin
        ovf = 1'b0;
        case (op)
            VXM_ADD: ovf = (add_lo < a);
            VXM_SUB: ovf = (a < b);
            VXM_MUL: ovf = |mul_hi;
            default: ovf = 1'b0;
        endcase
        sat = mask && ovf;
        if (!mask) begin
            result = a;
        end else if (ovf) begin
            result = (op == VXM_SUB) ? '0 : '1;
        end else begin
            result = alu;
        end
    end
`else
    assign result = mask ? alu : a;
`endif

endmodule

// File: rtl/vector_execution_pipe.sv
// rtl/vector_execution_pipe.sv - 2-stage masked lane-wise vector ALU with valid/ready, optional VXM_SATURATE_EN
module vector_execution_pipe
    import vxm_pkg::*;
#(
    parameter int LANE_WIDTH = VXM_LANE_WIDTH,
    parameter int NUM_TILES  = VXM_NUM_TILES,
    parameter int CNT_WIDTH  = VXM_CNT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  vxm_op_t               in_op,
    input  logic [NUM_TILES-1:0]  in_mask,
    input  logic [LANE_WIDTH-1:0] srf_data1 [NUM_TILES],
    input  logic [LANE_WIDTH-1:0] srf_data2 [NUM_TILES],
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [LANE_WIDTH-1:0] vxm_result [NUM_TILES],
    output vxm_op_t               out_op,
`ifdef VXM_SATURATE_EN
    output logic                  sat_flag,
`endif
    output logic [CNT_WIDTH-1:0]  ops_retired
);

    // Stage 1: captured operands
    logic                  s1_valid_q, s1_valid_d;
    vxm_op_t               s1_op_q, s1_op_d;
    logic [NUM_TILES-1:0]  s1_mask_q, s1_mask_d;
    logic [LANE_WIDTH-1:0] s1_a_q [NUM_TILES];
    logic [LANE_WIDTH-1:0] s1_a_d [NUM_TILES];
    logic [LANE_WIDTH-1:0] s1_b_q [NUM_TILES];
    logic [LANE_WIDTH-1:0] s1_b_d [NUM_TILES];

    // Stage 2: registered result
    logic                  out_valid_q, out_valid_d;
    vxm_op_t               out_op_q, out_op_d;
    logic [LANE_WIDTH-1:0] res_q [NUM_TILES];
    logic [LANE_WIDTH-1:0] res_d [NUM_TILES];
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

    logic [LANE_WIDTH-1:0] lane_res [NUM_TILES];
    logic                  s2_load;
    logic                  s1_load;

`ifdef VXM_SATURATE_EN
    logic [NUM_TILES-1:0]  lane_sat;
    logic                  out_sat_q, out_sat_d;
    logic                  sat_flag_q, sat_flag_d;
`endif

    for (genvar i = 0; i < NUM_TILES; i++) begin : g_lane
        vxm_lane_alu #(
            .LANE_WIDTH(LANE_WIDTH)
        ) u_alu (
            .a      (s1_a_q[i]),
            .b      (s1_b_q[i]),
            .op     (s1_op_q),
            .mask   (s1_mask_q[i]),
`ifdef VXM_SATURATE_EN
            .sat    (lane_sat[i]),
`endif
            .result (lane_res[i])
        );
    end

    // A stage advances when its downstream neighbour is empty or draining this cycle
    always_comb begin
        s2_load = !out_valid_q || out_ready;
        s1_load = !s1_valid_q || s2_load;
    end

    // Next-state for both stages and the retired counter
    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_op_d     = s1_op_q;
        s1_mask_d   = s1_mask_q;
        s1_a_d      = s1_a_q;
        s1_b_d      = s1_b_q;
        out_valid_d = out_valid_q;
        out_op_d    = out_op_q;
        res_d       = res_q;
        cnt_d       = cnt_q;
`ifdef VXM_SATURATE_EN
        out_sat_d   = out_sat_q;
        sat_flag_d  = sat_flag_q;
`endif
        if (s1_load) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_op_d   = in_op;
                s1_mask_d = in_mask;
                s1_a_d    = srf_data1;
                s1_b_d    = srf_data2;
            end
        end
        if (s2_load) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_op_d = s1_op_q;
                res_d    = lane_res;
`ifdef VXM_SATURATE_EN
                out_sat_d = |lane_sat;
`endif
            end
        end
        if (out_valid_q && out_ready) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
`ifdef VXM_SATURATE_EN
            sat_flag_d = sat_flag_q | out_sat_q;
`endif
        end
    end

    // State registers; reset flushes both stages and clears the held result
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_op_q     <= VXM_ADD;
            s1_mask_q   <= '0;
            s1_a_q      <= '{default: '0};
            s1_b_q      <= '{default: '0};
            out_valid_q <= 1'b0;
            out_op_q    <= VXM_ADD;
            res_q       <= '{default: '0};
            cnt_q       <= '0;
`ifdef VXM_SATURATE_EN
            out_sat_q   <= 1'b0;
            sat_flag_q  <= 1'b0;
`endif
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_op_q     <= s1_op_d;
            s1_mask_q   <= s1_mask_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            out_valid_q <= out_valid_d;
            out_op_q    <= out_op_d;
            res_q       <= res_d;
            cnt_q       <= cnt_d;
`ifdef VXM_SATURATE_EN
            out_sat_q   <= out_sat_d;
            sat_flag_q  <= sat_flag_d;
`endif
        end
    end

    assign in_ready    = s1_load;
    assign out_valid   = out_valid_q;
    assign out_op      = out_op_q;
    assign vxm_result  = res_q;
    assign ops_retired = cnt_q;
`ifdef VXM_SATURATE_EN
    assign sat_flag    = sat_flag_q;
`endif

endmodule

// File: tb/tb_vector_execution_pipe.sv
// tb/tb_vector_execution_pipe.sv - self-checking bench for vector_execution_pipe
module tb_vector_execution_pipe;
    import vxm_pkg::*;

    localparam int LW = 16;
    localparam int NT = 20;

    typedef logic [LW-1:0] lane_arr_t [NT];

`ifdef VXM_SATURATE_EN
    localparam logic [LW-1:0] EXP_ADD_WRAP = 16'hFFFF;
    localparam logic [LW-1:0] EXP_SUB_WRAP = 16'h0000;
    localparam logic [LW-1:0] EXP_MUL_WRAP = 16'hFFFF;
`else
    localparam logic [LW-1:0] EXP_ADD_WRAP = 16'h0010;
    localparam logic [LW-1:0] EXP_SUB_WRAP = 16'hFFFC;
    localparam logic [LW-1:0] EXP_MUL_WRAP = 16'h0100;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    vxm_op_t       in_op = VXM_ADD;
    logic [NT-1:0] in_mask = '0;
    lane_arr_t     srf_data1;
    lane_arr_t     srf_data2;
    logic          out_valid;
    logic          out_ready = 1'b1;
    lane_arr_t     vxm_result;
    vxm_op_t       out_op;
    logic [31:0]   ops_retired;
`ifdef VXM_SATURATE_EN
    logic          sat_flag;
`endif

    int passes = 0;
    int total  = 0;
    int unsigned cyc = 0;

    // Scoreboard of accepted vectors, oldest first
    logic [NT*LW-1:0] q_res [$];
    vxm_op_t          q_op [$];
    bit               q_sat [$];
    int unsigned      q_edge [$];

    // Monitor state
    bit               was_reset = 1'b0;
    bit               stall_prev = 1'b0;
    logic [NT*LW-1:0] prev_res = '0;
    vxm_op_t          prev_op = VXM_ADD;
    logic [31:0]      mcnt = '0;
    bit               msat = 1'b0;

    vector_execution_pipe dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_mask    (in_mask),
        .srf_data1  (srf_data1),
        .srf_data2  (srf_data2),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .vxm_result (vxm_result),
        .out_op     (out_op),
`ifdef VXM_SATURATE_EN
        .sat_flag   (sat_flag),
`endif
        .ops_retired(ops_retired)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act === req) passes++;
        else $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    endtask

    task automatic chk_vec(input string name, input logic [NT*LW-1:0] act, input logic [NT*LW-1:0] req);
        int bad;
        total++;
        if (act === req) begin
            passes++;
        end else begin
            bad = 0;
            for (int i = NT - 1; i >= 0; i--)
                if (act[i*LW +: LW] !== req[i*LW +: LW]) bad = i;
            $display("FAIL %s: lane %0d actual=%0h required=%0h", name, bad,
                     act[bad*LW +: LW], req[bad*LW +: LW]);
        end
    endtask

    function automatic logic [NT*LW-1:0] pack(input lane_arr_t v);
        logic [NT*LW-1:0] p;
        for (int i = 0; i < NT; i++) p[i*LW +: LW] = v[i];
        return p;
    endfunction

    // Reference lane: exact integer arithmetic, then wrap or clamp to the lane range
    function automatic logic [LW-1:0] model_lane(input vxm_op_t op, input logic [LW-1:0] a,
                                                 input logic [LW-1:0] b, input logic m, output bit s);
        longint ia, ib, r;
        ia = longint'({48'd0, a});
        ib = longint'({48'd0, b});
        r = 0;
        s = 1'b0;
        if (!m) return a;
        case (op)
            VXM_ADD: r = ia + ib;
            VXM_SUB: r = ia - ib;
            VXM_MUL: r = ia * ib;
            VXM_MAX: r = (ia > ib) ? ia : ib;
            VXM_MIN: r = (ia < ib) ? ia : ib;
            VXM_AND: r = ia & ib;
            VXM_OR:  r = ia | ib;
            VXM_XOR: r = ia ^ ib;
            default: r = ia;
        endcase
`ifdef VXM_SATURATE_EN
        if (r > 65535) begin
            r = 65535;
            s = 1'b1;
        end else if (r < 0) begin
            r = 0;
            s = 1'b1;
        end
`endif
        return r[LW-1:0];
    endfunction

    // Compare process: checks every cycle against the scoreboard
    initial begin : monitor
        logic [NT*LW-1:0] cur;
        logic [NT*LW-1:0] e;
        bit exp_valid;
        bit s;
        bit vs;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                q_res.delete();
                q_op.delete();
                q_sat.delete();
                q_edge.delete();
                mcnt = '0;
                msat = 1'b0;
                was_reset = 1'b1;
                stall_prev = 1'b0;
                continue;
            end
            cur = pack(vxm_result);
            if (was_reset) begin
                chk_vec("reset_result", cur, '0);
                chk("reset_out_op", 32'(out_op), 32'd0);
                was_reset = 1'b0;
            end
            exp_valid = (q_edge.size() > 0) && (q_edge[0] + 1 <= cyc);
            chk("out_valid", 32'(out_valid), 32'(exp_valid));
            chk("ops_retired", ops_retired, mcnt);
            chk("in_ready", 32'(in_ready), 32'((q_edge.size() < 2) || out_ready));
`ifdef VXM_SATURATE_EN
            chk("sat_flag", 32'(sat_flag), 32'(msat));
`endif
            if (stall_prev) begin
                chk_vec("stall_hold", cur, prev_res);
                chk("stall_op", 32'(out_op), 32'(prev_op));
            end
            if (out_valid && out_ready) begin
                if (q_res.size() == 0) begin
                    chk("spurious_output", 32'd1, 32'd0);
                end else begin
                    chk_vec("result", cur, q_res[0]);
                    chk("out_op", 32'(out_op), 32'(q_op[0]));
                    if (q_sat[0]) msat = 1'b1;
                    void'(q_res.pop_front());
                    void'(q_op.pop_front());
                    void'(q_sat.pop_front());
                    void'(q_edge.pop_front());
                    mcnt = mcnt + 32'd1;
                end
            end
            if (in_valid && in_ready) begin
                vs = 1'b0;
                for (int i = 0; i < NT; i++) begin
                    e[i*LW +: LW] = model_lane(in_op, srf_data1[i], srf_data2[i], in_mask[i], s);
                    vs |= s;
                end
                q_res.push_back(e);
                q_op.push_back(in_op);
                q_sat.push_back(vs);
                q_edge.push_back(cyc + 1);
            end
            stall_prev = out_valid && !out_ready;
            prev_res = cur;
            prev_op = out_op;
        end
    end

    task automatic send(input vxm_op_t op, input logic [NT-1:0] m, input lane_arr_t a, input lane_arr_t b);
        bit done = 1'b0;
        in_valid = 1'b1;
        in_op = op;
        in_mask = m;
        srf_data1 = a;
        srf_data2 = b;
        for (int g = 0; g < 100 && !done; g++) begin
            @(negedge clk);
            done = in_ready;
            @(posedge clk);
            #1;
        end
        if (!done) chk("send_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat, output logic [NT*LW-1:0] got);
        lat = 0;
        got = '0;
        for (int n = 1; n <= 50; n++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = n;
                got = pack(vxm_result);
                break;
            end
        end
        if (lat == 0) chk("wait_out_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic run1(input vxm_op_t op, input logic [NT-1:0] m, input logic [LW-1:0] av,
                        input logic [LW-1:0] bv, output logic [NT*LW-1:0] got);
        lane_arr_t a, b;
        int lat;
        for (int i = 0; i < NT; i++) begin
            a[i] = av;
            b[i] = bv;
        end
        send(op, m, a, b);
        wait_out(lat, got);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin : main
        lane_arr_t a, b;
        logic [NT*LW-1:0] got;
        logic [NT*LW-1:0] hold;
        int lat;

        for (int i = 0; i < NT; i++) begin
            srf_data1[i] = '0;
            srf_data2[i] = '0;
        end
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_ops_retired", ops_retired, 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Single ADD: latency and lane values
        for (int i = 0; i < NT; i++) begin
            a[i] = LW'(i);
            b[i] = 16'd100;
        end
        send(VXM_ADD, '1, a, b);
        wait_out(lat, got);
        chk("add_latency", lat, 32'd2);
        for (int i = 0; i < NT; i++) chk("add_lane", 32'(got[i*LW +: LW]), 32'(100 + i));
        chk("add_ops_retired", ops_retired, 32'd1);

        // Wrap or saturate boundaries
        run1(VXM_ADD, '1, 16'hFFF0, 16'h0020, got);
        chk("add_wrap_l0", 32'(got[0 +: LW]), 32'(EXP_ADD_WRAP));
        chk("add_wrap_l19", 32'(got[19*LW +: LW]), 32'(EXP_ADD_WRAP));
`ifdef VXM_SATURATE_EN
        chk("add_sat_flag", 32'(sat_flag), 32'd1);
`endif
        run1(VXM_SUB, '1, 16'h0005, 16'h0009, got);
        chk("sub_wrap_l0", 32'(got[0 +: LW]), 32'(EXP_SUB_WRAP));
        run1(VXM_MUL, '1, 16'h0100, 16'h0101, got);
        chk("mul_wrap_l0", 32'(got[0 +: LW]), 32'(EXP_MUL_WRAP));

        // Mask 0x00005 with A=7, B=3
        run1(VXM_MAX, 20'h00005, 16'd7, 16'd3, got);
        chk("max_l0", 32'(got[0 +: LW]), 32'd7);
        chk("max_l1", 32'(got[1*LW +: LW]), 32'd7);
        chk("max_l2", 32'(got[2*LW +: LW]), 32'd7);
        run1(VXM_MIN, 20'h00005, 16'd7, 16'd3, got);
        chk("min_l0", 32'(got[0 +: LW]), 32'd3);
        chk("min_l1", 32'(got[1*LW +: LW]), 32'd7);
        chk("min_l2", 32'(got[2*LW +: LW]), 32'd3);
        chk("min_l19", 32'(got[19*LW +: LW]), 32'd7);
        run1(VXM_XOR, 20'h00005, 16'd7, 16'd3, got);
        chk("xor_l0", 32'(got[0 +: LW]), 32'd4);
        chk("xor_l1", 32'(got[1*LW +: LW]), 32'd7);
        chk("xor_l2", 32'(got[2*LW +: LW]), 32'd4);

        // All-zero mask still yields a valid vector equal to operand A
        for (int i = 0; i < NT; i++) begin
            a[i] = LW'(i * 3);
            b[i] = 16'd5;
        end
        send(VXM_ADD, '0, a, b);
        wait_out(lat, got);
        chk("mask0_latency", lat, 32'd2);
        chk("mask0_l7", 32'(got[7*LW +: LW]), 32'd21);
        chk("mask0_l19", 32'(got[19*LW +: LW]), 32'd57);

        // Every opcode back-to-back with varied lanes, scoreboard-checked
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < NT; i++) begin
                a[i] = LW'(i * 1234 + k * 4099 + 17);
                b[i] = LW'(~(i * 771 + k * 3));
            end
            send(vxm_op_t'(k), 20'hA5F3C ^ NT'(k), a, b);
        end
        repeat (4) @(posedge clk);
        #1;

        // Backpressure: five vectors, consumer stalls in cycles 3-6
        pulse_reset();
        fork
            begin
                for (int k = 0; k < 5; k++) begin
                    for (int i = 0; i < NT; i++) begin
                        a[i] = LW'(k * 10 + i);
                        b[i] = 16'd1;
                    end
                    send(VXM_ADD, '1, a, b);
                end
            end
            begin
                repeat (3) begin @(posedge clk); #1; end
                out_ready = 1'b0;
                @(negedge clk);
                chk("bp_in_ready", 32'(in_ready), 32'd0);
                chk("bp_out_valid", 32'(out_valid), 32'd1);
                hold = pack(vxm_result);
                repeat (3) begin @(posedge clk); #1; end
                @(negedge clk);
                chk_vec("bp_hold", pack(vxm_result), hold);
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        repeat (6) @(posedge clk);
        #1;
        chk("bp_ops_retired", ops_retired, 32'd5);
        chk("bp_drained", 32'(out_valid), 32'd0);

        // Reset with both stages full
        out_ready = 1'b0;
        for (int i = 0; i < NT; i++) begin
            a[i] = LW'(500 + i);
            b[i] = 16'd9;
        end
        send(VXM_OR, '1, a, b);
        send(VXM_AND, '1, a, b);
        @(negedge clk);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        pulse_reset();
        @(negedge clk);
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk_vec("mid_rst_result", pack(vxm_result), '0);
        chk("mid_rst_ops", ops_retired, 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        @(posedge clk);
        #1;

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
